mix_columns_engine: RTL and testbench
=====================================

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning the number of 32-bit columns transformed per clock; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter OUT_REG, default 1, meaning 1 = registered data_out, 0 = data_out driven from the working register.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: data_in and inverse are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the engine can accept a state.
REQ-007 SHALL have port data_in, input, 128 bits: AES state; column c = bits[127-32c -: 32], row 0 in the MSB byte of each column.
REQ-008 SHALL have port inverse, input, 1 bit: 0 = MixColumns, 1 = InvMixColumns; sampled at acceptance.
REQ-009 SHALL have port out_valid, output, 1 bit: data_out holds a finished result.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port data_out, output, 128 bits: transformed state, same layout as data_in.
REQ-012 SHALL have port busy, output, 1 bit: high in BUSY or DONE.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-014 SHALL assert in_ready only in IDLE; acceptance is in_valid && in_ready.
REQ-015 On acceptance SHALL load data_in into the working register, latch inverse, clear the group counter and enter BUSY.
REQ-016 In BUSY SHALL, each cycle, transform column group g (columns g*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1) in place and increment g.
REQ-017 SHALL leave BUSY after N = 4/COLS_PER_CYCLE cycles and enter DONE with out_valid high; out_valid therefore rises N cycles after the acceptance edge (OUT_REG=1 results load on the final BUSY edge).
REQ-018 Forward mode SHALL compute each output byte as 02·a0^03·a1^01·a2^01·a3, with the matrix rotated per row.
REQ-019 Inverse mode SHALL compute each output byte as 0e·a0^0b·a1^0d·a2^09·a3, with the matrix rotated per row.
REQ-020 GF(2^8) products SHALL be built from xtime, (x<<1)^(x[7]?8'h1b:0); 256-entry lookup tables are not used.
REQ-021 In DONE SHALL hold data_out and out_valid stable until out_valid && out_ready.
REQ-022 On the handshake in REQ-021 SHALL return to IDLE (in_ready high the next cycle); there is no same-cycle re-accept.
REQ-023 in_valid asserted in BUSY or DONE SHALL be ignored and SHALL NOT corrupt state.
REQ-024 A change on inverse after acceptance SHALL NOT affect the operation in flight.
REQ-025 The group counter SHALL be ceil(log2(N)) bits wide (minimum 1 bit) and SHALL NOT wrap while in BUSY.
REQ-026 When COLS_PER_CYCLE=4 SHALL spend exactly one cycle in BUSY.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, in_ready=1 (once rst_n is high), out_valid=0, busy=0, data_out=0, working register=0, counter=0 and latched mode=0.
REQ-028 Reset asserted mid-operation SHALL discard the state in flight; no out_valid pulse SHALL follow reset release.
REQ-029 Reset release SHALL be synchronous-deasserted externally; the block adds no synchroniser.

Structure
REQ-030 A shared package aes_pkg SHALL hold the xtime/gf_mul helper functions, the AES polynomial constant 8'h1b, and the FSM state encoding.
REQ-031 SHALL instantiate COLS_PER_CYCLE copies of sub-module mix_column_unit: a combinational 32-bit column transform with an inverse select.
REQ-032 The multiplexing of column groups into and out of the units SHALL be done inside mix_columns_engine.

Verification
REQ-033 Forward, COLS_PER_CYCLE=1: columns db135345, f20a225c, 01010101, c6c6c6c6 -> 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6; out_valid 4 cycles after accept.
REQ-034 Inverse, COLS_PER_CYCLE=2: the output of REQ-033 -> original input; out_valid 2 cycles after accept.
REQ-035 Forward, COLS_PER_CYCLE=4: columns d4d4d4d5, 2d26314c, 00000000, ffffffff -> d5d5d7d6, 4d7ebdf8, 00000000, ffffffff; out_valid 1 cycle after accept.
REQ-036 Backpressure: out_ready low for 10 cycles in DONE -> data_out stable, in_ready 0, and a second in_valid ignored; out_ready high -> IDLE the next cycle.
REQ-037 rst_n pulsed low in the 2nd BUSY cycle -> all outputs at reset values immediately, no out_valid afterwards; a fresh operation then completes correctly.
REQ-038 Random round-trip, 1000 states, all COLS_PER_CYCLE values: an inverse-mode pass applied to a forward-mode result -> equals the original state.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared GF(2^8) helpers, AES polynomial and engine FSM encoding
package aes_pkg;
   localparam logic [7:0] AES_POLY = 8'h1b;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
   endfunction
   // m is a 4-bit multiplier; covers every MixColumns/InvMixColumns coefficient
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
      logic [7:0] a2, a4, a8;
      a2 = xtime(a);
      a4 = xtime(a2);
      a8 = xtime(a4);
      return (m[0] ? a : 8'h00) ^ (m[1] ? a2 : 8'h00) ^ (m[2] ? a4 : 8'h00) ^ (m[3] ? a8 : 8'h00);
   endfunction
endpackage

// File: rtl/mix_column_unit.sv
// mix_column_unit: combinational MixColumns/InvMixColumns of one 32-bit column
module mix_column_unit
   import aes_pkg::*;
(
   input  logic [31:0] col,
   input  logic        inverse,
   output logic [31:0] res
);
   logic [7:0] a  [4];
   logic [3:0] co [4];
   always_comb begin
      for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
      co[0] = inverse ? 4'he : 4'h2;
      co[1] = inverse ? 4'hb : 4'h3;
      co[2] = inverse ? 4'hd : 4'h1;
      co[3] = inverse ? 4'h9 : 4'h1;
      res = '0;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            res[31-8*r -: 8] = res[31-8*r -: 8] ^ gf_mul(a[2'(r+k)], co[k]);
   end
endmodule

// File: rtl/mix_columns_engine.sv
// mix_columns_engine: iterative AES (Inv)MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock
module mix_columns_engine
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1,
   parameter int OUT_REG        = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   input  logic         inverse,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy
);
   localparam int N  = 4 / COLS_PER_CYCLE;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   state_e state_q, state_d;
   logic [127:0] work_q, work_d, dout_q;
   logic [CW-1:0] grp_q;
   logic inv_q, accept, last;
   logic [32*COLS_PER_CYCLE-1:0] lane_in, lane_out;
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign busy      = state_q != IDLE;
   assign accept    = in_valid && in_ready;
   assign last      = grp_q == CW'(N - 1);
   assign data_out  = OUT_REG != 0 ? dout_q : work_q;
   // route the active column group to the units and write results back in place
   always_comb begin
      lane_in = '0;
      work_d  = work_q;
      for (int c = 0; c < 4; c++)
         if (grp_q == CW'(c / COLS_PER_CYCLE)) begin
            lane_in[32*(c % COLS_PER_CYCLE) +: 32] = work_q[127-32*c -: 32];
            work_d[127-32*c -: 32] = lane_out[32*(c % COLS_PER_CYCLE) +: 32];
         end
   end
   for (genvar u = 0; u < COLS_PER_CYCLE; u++) begin : g_unit
      mix_column_unit u_mcu (
         .col    (lane_in[32*u +: 32]),
         .inverse(inv_q),
         .res    (lane_out[32*u +: 32])
      );
   end
   always_comb begin
      state_d = state_q == IDLE ? (in_valid ? BUSY : IDLE)
              : state_q == BUSY ? (last ? DONE : BUSY)
              : (out_ready ? IDLE : DONE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         dout_q  <= '0;
         grp_q   <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            work_q <= data_in;
            inv_q  <= inverse;
            grp_q  <= '0;
         end else if (state_q == BUSY) begin
            work_q <= work_d;
            if (!last) grp_q <= grp_q + 1'b1;
         end
         if (OUT_REG != 0 && state_q == BUSY && last) dout_q <= work_d;
      end
   end
endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: scoreboard bench over COLS_PER_CYCLE = 1, 2, 4 instances
module tb_mix_columns_engine;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] in_valid, in_ready, inverse, out_valid, out_ready, busy;
   logic [127:0] data_in [3];
   logic [127:0] data_out [3];
   logic [127:0] sb [$];
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   for (genvar k = 0; k < 3; k++) begin : g_dut
      mix_columns_engine #(.COLS_PER_CYCLE(1 << k)) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid[k]),
         .in_ready (in_ready[k]),
         .data_in  (data_in[k]),
         .inverse  (inverse[k]),
         .out_valid(out_valid[k]),
         .out_ready(out_ready[k]),
         .data_out (data_out[k]),
         .busy     (busy[k])
      );
   end
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction
   function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
      logic [7:0] co [4];
      logic [7:0] a [4];
      logic [127:0] o = '0;
      co[0] = inv ? 8'h0e : 8'h02;
      co[1] = inv ? 8'h0b : 8'h03;
      co[2] = inv ? 8'h0d : 8'h01;
      co[3] = inv ? 8'h09 : 8'h01;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) a[r] = d[127-32*c-8*r -: 8];
         for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
               o[127-32*c-8*r -: 8] ^= gm(a[(r+k)%4], co[k]);
      end
      return o;
   endfunction
   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   task automatic do_op(input int k, input logic [127:0] d, input logic inv,
                        output logic [127:0] res, output int lat);
      @(negedge clk);
      data_in[k] = d;
      inverse[k] = inv;
      in_valid[k] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      inverse[k] = ~inv;
      data_in[k] = ~d;
      lat = 0;
      while (!out_valid[k] && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = data_out[k];
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[k] = 1'b0;
   endtask
   task automatic test_reset();
      #1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || data_out[k] !== '0) begin
            bad++;
            $display("FAIL reset[%0d]: got ov=%b busy=%b dout=%h want 0 0 0", k, out_valid[k], busy[k], data_out[k]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 3'b111) begin
         bad++;
         $display("FAIL reset_in_ready: got %b want 111", in_ready);
      end
   endtask
   task automatic test_vector(input string name, input int k, input logic [127:0] d,
                              input logic inv, input logic [127:0] exp, input int exp_lat);
      logic [127:0] res, e;
      int lat;
      sb.push_back(exp);
      do_op(k, d, inv, res, lat);
      e = sb.pop_front();
      total++;
      if (res !== e) begin
         bad++;
         $display("FAIL %s_data: got %h want %h", name, res, e);
      end
      total++;
      if (lat !== exp_lat) begin
         bad++;
         $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
      end
   endtask
   task automatic test_backpressure();
      logic [127:0] d, held, e;
      int lat = 0;
      d = rnd128();
      sb.push_back(model(d, 1'b0));
      @(negedge clk);
      data_in[1] = d;
      inverse[1] = 1'b0;
      in_valid[1] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[1] = 1'b0;
      while (!out_valid[1] && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      held = data_out[1];
      e = sb.pop_front();
      total++;
      if (held !== e || lat !== 2) begin
         bad++;
         $display("FAIL bp_result: got %h lat %0d want %h lat 2", held, lat, e);
      end
      for (int i = 0; i < 10; i++) begin
         data_in[1] = rnd128();
         inverse[1] = 1'b1;
         in_valid[1] = 1'b1;
         @(posedge clk);
         #1;
         total++;
         if (data_out[1] !== held || in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold[%0d]: got dout=%h ir=%b ov=%b want %h 0 1", i, data_out[1], in_ready[1], out_valid[1], held);
         end
      end
      out_ready[1] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[1] = 1'b0;
      total++;
      if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
         bad++;
         $display("FAIL bp_release: got ir=%b ov=%b busy=%b want 1 0 0", in_ready[1], out_valid[1], busy[1]);
      end
      in_valid[1] = 1'b0;
      test_vector("bp_after", 1, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                  128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 2);
   endtask
   task automatic test_reset_mid();
      int seen = 0;
      @(negedge clk);
      data_in[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      inverse[0] = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || data_out[0] !== '0) begin
         bad++;
         $display("FAIL rst_mid: got ov=%b busy=%b dout=%h want 0 0 0", out_valid[0], busy[0], data_out[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (out_valid[0]) seen++;
      end
      total++;
      if (seen !== 0 || in_ready[0] !== 1'b1) begin
         bad++;
         $display("FAIL rst_after: got %0d out_valid cycles ir=%b want 0 1", seen, in_ready[0]);
      end
      test_vector("rst_fresh", 0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                  128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4);
   endtask
   task automatic test_random();
      logic [127:0] d, f, b, e;
      int lat;
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 1000; i++) begin
            d = rnd128();
            sb.push_back(model(d, 1'b0));
            sb.push_back(d);
            do_op(k, d, 1'b0, f, lat);
            e = sb.pop_front();
            total++;
            if (f !== e || lat !== (4 >> k)) begin
               bad++;
               $display("FAIL rand_fwd[%0d]: got %h lat %0d want %h lat %0d", k, f, lat, e, 4 >> k);
            end
            do_op(k, f, 1'b1, b, lat);
            e = sb.pop_front();
            total++;
            if (b !== e) begin
               bad++;
               $display("FAIL rand_roundtrip[%0d]: got %h want %h", k, b, e);
            end
         end
   endtask
   initial begin
      in_valid = '0;
      out_ready = '0;
      inverse = '0;
      foreach (data_in[k]) data_in[k] = '0;
      test_reset();
      test_vector("fwd_c1", 0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                  128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4);
      test_vector("inv_c2", 1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
                  128'hdb135345_f20a225c_01010101_c6c6c6c6, 2);
      test_vector("fwd_c4", 2, 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0,
                  128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 1);
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
